reg_stat_mp: RTL

//  Parametrised multi-port register status table for the out-of-order dispatch stage: architectural

---
 rtl/reg_stat_mp_pkg.sv | 23 ++
 rtl/reg_stat_mp_if.sv | 35 +++
 rtl/reg_stat_mp_rdport.sv | 41 ++++
 rtl/reg_stat_mp.sv | 73 +++++++
 4 files changed

// File: rtl/reg_stat_mp_pkg.sv
// Shared types and sizing for the multi-port register status table.
// Data word, register address and rename tag types plus the unlocked/zero constants.
package reg_stat_mp_pkg;
    localparam int XLEN      = 32;
    localparam int REG_AW    = 5;
    localparam int TAG_W     = 4;
    localparam int REG_COUNT = 2 ** REG_AW;
    localparam int NUM_RD    = 4;
    localparam int NUM_REN   = 2;
    localparam int NUM_CM    = 3;

    typedef logic [XLEN-1:0]   word_t;
    typedef logic [REG_AW-1:0] regaddr_t;
    typedef logic [TAG_W-1:0]  regtag_t;

    localparam regtag_t UNLOCKED = '0;
    localparam word_t   ZERO     = '0;

    // r0 is hardwired: never renamed, never written, never bypassed
    function automatic logic is_r0(input regaddr_t a);
        return a == '0;
    endfunction
endpackage

// File: rtl/reg_stat_mp_if.sv
// Dispatch/commit bus of the register status table.
// master = dispatch/commit side driving requests, slave = the table.
interface reg_stat_mp_if;
    import reg_stat_mp_pkg::*;

    logic                           rdy;
    logic                           flush;
    logic     [NUM_RD-1:0]          rd_en;
    regaddr_t [NUM_RD-1:0]          rd_addr;
    word_t    [NUM_RD-1:0]          rd_imm;
    word_t    [NUM_RD-1:0]          rd_data;
    regtag_t  [NUM_RD-1:0]          rd_tag;
    logic     [NUM_REN-1:0]         ren_en;
    regaddr_t [NUM_REN-1:0]         ren_addr;
    regtag_t  [NUM_REN-1:0]         ren_tag;
    logic     [NUM_CM-1:0]          cm_en;
    regaddr_t [NUM_CM-1:0]          cm_addr;
    regtag_t  [NUM_CM-1:0]          cm_tag;
    word_t    [NUM_CM-1:0]          cm_data;
    logic     [REG_COUNT-1:0]       lock_vec;

    modport master (
        output rdy, flush, rd_en, rd_addr, rd_imm,
        output ren_en, ren_addr, ren_tag,
        output cm_en, cm_addr, cm_tag, cm_data,
        input  rd_data, rd_tag, lock_vec
    );

    modport slave (
        input  rdy, flush, rd_en, rd_addr, rd_imm,
        input  ren_en, ren_addr, ren_tag,
        input  cm_en, cm_addr, cm_tag, cm_data,
        output rd_data, rd_tag, lock_vec
    );
endinterface

// File: rtl/reg_stat_mp_rdport.sv
// One combinational operand read mux: immediate select, r0 forcing, and
// (with REG_STAT_BYPASS_EN defined) same-cycle commit bypass on tag match.
module reg_stat_rdport
    import reg_stat_mp_pkg::*;
(
    input  logic                   en,
    input  regaddr_t               addr,
    input  word_t                  imm,
    input  word_t                  st_data,
    input  regtag_t                st_tag,
`ifdef REG_STAT_BYPASS_EN
    input  logic     [NUM_CM-1:0]  cm_en,
    input  regaddr_t [NUM_CM-1:0]  cm_addr,
    input  regtag_t  [NUM_CM-1:0]  cm_tag,
    input  word_t    [NUM_CM-1:0]  cm_data,
`endif
    output word_t                  rd_data,
    output regtag_t                rd_tag
);
    always_comb begin
        rd_data = st_data;
        rd_tag  = st_tag;
`ifdef REG_STAT_BYPASS_EN
        // ascending scan so the highest matching commit port wins
        for (int c = 0; c < NUM_CM; c++) begin
            if (cm_en[c] && cm_addr[c] == addr && cm_tag[c] == st_tag) begin
                rd_data = cm_data[c];
                rd_tag  = UNLOCKED;
            end
        end
`endif
        if (is_r0(addr)) begin
            rd_data = ZERO;
            rd_tag  = UNLOCKED;
        end
        if (!en) begin
            rd_data = imm;
            rd_tag  = UNLOCKED;
        end
    end
endmodule

// File: rtl/reg_stat_mp.sv
// Multi-port register status table: architectural data + rename tag per register.
// Optional same-cycle commit bypass on reads when REG_STAT_BYPASS_EN is defined.
module reg_stat_mp
    import reg_stat_mp_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    reg_stat_mp_if.slave   bus
);
    word_t                data_q [REG_COUNT];
    word_t                data_d [REG_COUNT];
    regtag_t              tag_q  [REG_COUNT];
    regtag_t              tag_d  [REG_COUNT];
    logic [REG_COUNT-1:0] lock_q;
    logic [REG_COUNT-1:0] lock_d;

    // Next-state: commits first, then flush or renames override tags.
    // Commit matching always looks at tag_q, so a same-cycle rename is never matched.
    always_comb begin
        data_d = data_q;
        tag_d  = tag_q;
        for (int c = 0; c < NUM_CM; c++) begin
            if (bus.cm_en[c] && !is_r0(bus.cm_addr[c])) begin
                data_d[bus.cm_addr[c]] = bus.cm_data[c];
                if (tag_q[bus.cm_addr[c]] == bus.cm_tag[c])
                    tag_d[bus.cm_addr[c]] = UNLOCKED;
            end
        end
        if (bus.flush) begin
            for (int r = 0; r < REG_COUNT; r++)
                tag_d[r] = UNLOCKED;
        end else begin
            for (int k = 0; k < NUM_REN; k++) begin
                if (bus.ren_en[k] && !is_r0(bus.ren_addr[k]))
                    tag_d[bus.ren_addr[k]] = bus.ren_tag[k];
            end
        end
        for (int r = 0; r < REG_COUNT; r++)
            lock_d[r] = (tag_d[r] != UNLOCKED);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '{default: ZERO};
            tag_q  <= '{default: UNLOCKED};
            lock_q <= '0;
        end else if (bus.rdy) begin
            data_q <= data_d;
            tag_q  <= tag_d;
            lock_q <= lock_d;
        end
    end

    assign bus.lock_vec = lock_q;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        reg_stat_rdport u_rdport (
            .en      (bus.rd_en[i]),
            .addr    (bus.rd_addr[i]),
            .imm     (bus.rd_imm[i]),
            .st_data (data_q[bus.rd_addr[i]]),
            .st_tag  (tag_q[bus.rd_addr[i]]),
`ifdef REG_STAT_BYPASS_EN
            .cm_en   (bus.cm_en),
            .cm_addr (bus.cm_addr),
            .cm_tag  (bus.cm_tag),
            .cm_data (bus.cm_data),
`endif
            .rd_data (bus.rd_data[i]),
            .rd_tag  (bus.rd_tag[i])
        );
    end
endmodule
